branch_condition_unit: RTL and testbench

Consumes the 5-bit saved flags produced by the flag register and resolves conditional branch/jump requests from decode against them. It tracks flag-setting instructions still in flight and holds a branch until every older flag write has landed. It then returns a taken/not-taken decision plus target to the fetch stage over a valid/ready handshake.

---
 rtl/bcu_pkg.sv | 39 +++
 rtl/branch_condition_unit_cond_evaluator.sv | 41 ++++
 rtl/branch_condition_unit.sv | 138 +++++++++++++
 tb/tb_branch_condition_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcu_pkg.sv
// Shared definitions for the branch condition unit: widths, flag bit
// positions, condition code encodings and the controller state type.
package bcu_pkg;

   localparam int unsigned COND_W = 4;
   localparam int unsigned FLAG_W = 5;

   // Bit positions inside SavedFlags
   localparam int unsigned FLAG_C = 0;
   localparam int unsigned FLAG_L = 1;
   localparam int unsigned FLAG_F = 2;
   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_N = 4;

   // Condition codes carried on ReqCond
   localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
   localparam logic [COND_W-1:0] COND_NE = 4'b0001;
   localparam logic [COND_W-1:0] COND_CS = 4'b0010;
   localparam logic [COND_W-1:0] COND_CC = 4'b0011;
   localparam logic [COND_W-1:0] COND_HI = 4'b0100;
   localparam logic [COND_W-1:0] COND_LS = 4'b0101;
   localparam logic [COND_W-1:0] COND_GT = 4'b0110;
   localparam logic [COND_W-1:0] COND_LE = 4'b0111;
   localparam logic [COND_W-1:0] COND_FS = 4'b1000;
   localparam logic [COND_W-1:0] COND_FC = 4'b1001;
   localparam logic [COND_W-1:0] COND_LO = 4'b1010;
   localparam logic [COND_W-1:0] COND_HS = 4'b1011;
   localparam logic [COND_W-1:0] COND_LT = 4'b1100;
   localparam logic [COND_W-1:0] COND_GE = 4'b1101;
   localparam logic [COND_W-1:0] COND_UC = 4'b1110;
   localparam logic [COND_W-1:0] COND_NV = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/branch_condition_unit_cond_evaluator.sv
// Combinational resolution of a condition code against the saved flags.
module cond_evaluator
   import bcu_pkg::*;
(
   input  logic [FLAG_W-1:0] SavedFlags,
   input  logic [COND_W-1:0] ReqCond,
   output logic              Taken
);

   logic w_c, w_l, w_f, w_z, w_n;

   assign w_c = SavedFlags[FLAG_C];
   assign w_l = SavedFlags[FLAG_L];
   assign w_f = SavedFlags[FLAG_F];
   assign w_z = SavedFlags[FLAG_Z];
   assign w_n = SavedFlags[FLAG_N];

   // Decode the condition code into a taken decision
   always_comb begin
      Taken = 1'b0;
      case (ReqCond)
         COND_EQ: Taken = w_z;
         COND_NE: Taken = ~w_z;
         COND_CS: Taken = w_c;
         COND_CC: Taken = ~w_c;
         COND_HI: Taken = w_l;
         COND_LS: Taken = ~w_l;
         COND_GT: Taken = w_n;
         COND_LE: Taken = ~w_n;
         COND_FS: Taken = w_f;
         COND_FC: Taken = ~w_f;
         COND_LO: Taken = ~w_l & ~w_z;
         COND_HS: Taken = w_l | w_z;
         COND_LT: Taken = ~w_n & ~w_z;
         COND_GE: Taken = w_n | w_z;
         COND_UC: Taken = 1'b1;
         COND_NV: Taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_condition_unit.sv
// Branch condition unit: holds a conditional branch until all older
// flag-setting instructions have written the flag register, then
// returns taken/target to fetch over a valid/ready handshake.
// Optional BCU_STATS_EN adds TakenCount and StallCycles outputs.
module branch_condition_unit
   import bcu_pkg::*;
#(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned MAX_PENDING = 3
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic [FLAG_W-1:0] SavedFlags,
   input  logic              FlagWriteIssue,
   input  logic              FlagWriteDone,
   input  logic              ReqValid,
   output logic              ReqReady,
   input  logic [COND_W-1:0] ReqCond,
   input  logic [ADDR_W-1:0] ReqTarget,
   output logic              RespValid,
   input  logic              RespReady,
   output logic              RespTaken,
   output logic [ADDR_W-1:0] RespTarget,
   output logic              FlagCntError
`ifdef BCU_STATS_EN
   ,
   output logic [15:0]       TakenCount,
   output logic [15:0]       StallCycles
`endif
);

   localparam int unsigned P_W = $clog2(MAX_PENDING + 1);
   localparam logic [P_W-1:0] P_MAX = P_W'(MAX_PENDING);

   state_e              r_state, w_next;
   logic [P_W-1:0]      r_pending;
   logic [P_W-1:0]      r_wait;
   logic                r_err;
   logic [COND_W-1:0]   r_cond;
   logic                r_taken;
   logic [ADDR_W-1:0]   r_target;

   logic                w_inc, w_dec, w_accept, w_p_zero, w_w_zero;
   logic [COND_W-1:0]   w_eval_cond;
   logic                w_eval_taken;

   assign w_inc    = FlagWriteIssue & ~FlagWriteDone;
   assign w_dec    = FlagWriteDone & ~FlagWriteIssue;
   assign w_accept = (r_state == ST_IDLE) & ReqValid;
   assign w_p_zero = (r_pending == '0);
   assign w_w_zero = (r_wait == '0);

   // Single evaluator: live condition on the IDLE fast path, captured one in WAIT
   assign w_eval_cond = (r_state == ST_IDLE) ? ReqCond : r_cond;

   cond_evaluator u_eval (
      .SavedFlags (SavedFlags),
      .ReqCond    (w_eval_cond),
      .Taken      (w_eval_taken)
   );

   // In-flight flag writer count with saturation and sticky error
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_pending <= '0;
         r_err     <= 1'b0;
      end else if (w_inc) begin
         if (r_pending == P_MAX) r_err <= 1'b1;
         else                    r_pending <= r_pending + 1'b1;
      end else if (w_dec) begin
         if (w_p_zero) r_err <= 1'b1;
         else          r_pending <= r_pending - 1'b1;
      end
   end

   // State register
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   // Next-state selection
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (ReqValid)  w_next = w_p_zero ? ST_RESP : ST_WAIT;
         ST_WAIT: if (w_w_zero)  w_next = ST_RESP;
         ST_RESP: if (RespReady) w_next = ST_IDLE;
         default:                w_next = ST_IDLE;
      endcase
   end

   // Request capture, older-writer wait count and registered decision.
   // A Done in the accept cycle retires one of the older writers, so it is
   // subtracted from the snapshot; an Issue in that cycle is younger and ignored.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_wait   <= '0;
         r_cond   <= '0;
         r_taken  <= 1'b0;
         r_target <= '0;
      end else if (w_accept) begin
         r_cond   <= ReqCond;
         r_target <= ReqTarget;
         if (w_p_zero) r_taken <= w_eval_taken;
         else          r_wait  <= r_pending - P_W'(FlagWriteDone);
      end else if (r_state == ST_WAIT) begin
         if (w_w_zero)           r_taken <= w_eval_taken;
         else if (FlagWriteDone) r_wait  <= r_wait - 1'b1;
      end
   end

   assign ReqReady     = (r_state == ST_IDLE);
   assign RespValid    = (r_state == ST_RESP);
   assign RespTaken    = r_taken;
   assign RespTarget   = r_target;
   assign FlagCntError = r_err;

`ifdef BCU_STATS_EN
   logic [15:0] r_taken_cnt;
   logic [15:0] r_stall_cnt;

   // Count handshaked taken responses and cycles spent waiting on flags
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_taken_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (RespValid && RespReady && r_taken) r_taken_cnt <= r_taken_cnt + 16'd1;
         if (r_state == ST_WAIT)                r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign TakenCount  = r_taken_cnt;
   assign StallCycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_branch_condition_unit.sv
// Self-checking bench for branch_condition_unit (build with or without
// BCU_STATS_EN). Directed steps followed by randomized requests.
module tb_branch_condition_unit;

   localparam int ADDR_W = 16;
   localparam int MAXP   = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [4:0]        flags;
   logic              issue, done;
   logic              req_valid, req_ready;
   logic [3:0]        req_cond;
   logic [ADDR_W-1:0] req_target;
   logic              resp_valid, resp_ready, resp_taken;
   logic [ADDR_W-1:0] resp_target;
   logic              err;
`ifdef BCU_STATS_EN
   logic [15:0]       taken_cnt, stall_cnt;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int m_p      = 0;
   bit m_err    = 0;
   int m_tc     = 0;

   branch_condition_unit #(.ADDR_W(ADDR_W), .MAX_PENDING(MAXP)) dut (
      .Clock          (clk),
      .Reset_n        (rst_n),
      .SavedFlags     (flags),
      .FlagWriteIssue (issue),
      .FlagWriteDone  (done),
      .ReqValid       (req_valid),
      .ReqReady       (req_ready),
      .ReqCond        (req_cond),
      .ReqTarget      (req_target),
      .RespValid      (resp_valid),
      .RespReady      (resp_ready),
      .RespTaken      (resp_taken),
      .RespTarget     (resp_target),
      .FlagCntError   (err)
`ifdef BCU_STATS_EN
      ,
      .TakenCount     (taken_cnt),
      .StallCycles    (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Conditions come in complementary pairs: even code = positive form,
   // odd code = its negation. Pair index selects the positive predicate.
   function automatic bit model_taken(input logic [4:0] f, input logic [3:0] cc);
      bit c, l, ff, z, n;
      bit [7:0] pos;
      int unsigned pair;
      c = f[0]; l = f[1]; ff = f[2]; z = f[3]; n = f[4];
      pos  = {1'b1, (!n && !z), (!l && !z), ff, n, l, c, z};
      pair = int'(cc) / 2;
      return pos[pair] ^ cc[0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; pending-count model follows the inputs sampled at the edge
   task automatic cycle();
      if (!rst_n) begin
         m_p = 0; m_err = 0;
      end else if (issue && !done) begin
         if (m_p == MAXP) m_err = 1; else m_p++;
      end else if (done && !issue) begin
         if (m_p == 0) m_err = 1; else m_p--;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [3:0] cc, input logic [ADDR_W-1:0] tgt);
      check("req_ready_before_accept", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_cond   = cc;
      req_target = tgt;
      cycle();
      req_valid  = 1'b0;
   endtask

   task automatic expect_resp(input string tag, input bit exp_taken, input logic [ADDR_W-1:0] exp_tgt);
      check({tag, "_valid"},  32'(resp_valid),  32'd1);
      check({tag, "_ready0"}, 32'(req_ready),   32'd0);
      check({tag, "_taken"},  32'(resp_taken),  32'(exp_taken));
      check({tag, "_target"}, 32'(resp_target), 32'(exp_tgt));
   endtask

   task automatic finish_resp(input bit exp_taken);
      resp_ready = 1'b1;
      cycle();
      resp_ready = 1'b0;
      m_tc += int'(exp_taken);
      check("resp_done_valid", 32'(resp_valid), 32'd0);
      check("resp_done_ready", 32'(req_ready),  32'd1);
   endtask

   initial begin
      logic [3:0]        cc;
      logic [4:0]        fl;
      logic [ADDR_W-1:0] tg;
      int                k, gap;

      rst_n = 1'b0; flags = '0; issue = 0; done = 0;
      req_valid = 0; req_cond = '0; req_target = '0; resp_ready = 0;

      // Reset state
      #2;
      check("rst_req_ready",   32'(req_ready),   32'd1);
      check("rst_resp_valid",  32'(resp_valid),  32'd0);
      check("rst_resp_taken",  32'(resp_taken),  32'd0);
      check("rst_resp_target", 32'(resp_target), 32'd0);
      check("rst_err",         32'(err),         32'd0);
`ifdef BCU_STATS_EN
      check("rst_taken_cnt", 32'(taken_cnt), 32'd0);
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      cycle(); cycle();
      rst_n = 1'b1;
      cycle();

      // No hazard: EQ with Z set, response next cycle
      flags = 5'b01000;
      accept(4'b0000, 16'h0040);
      expect_resp("eq_fast", 1'b1, 16'h0040);
      finish_resp(1'b1);

      // LO with all clear, then with Z, then never
      flags = 5'b00000;
      accept(4'b1010, 16'h0101);
      expect_resp("lo_clear", model_taken(flags, 4'b1010), 16'h0101);
      finish_resp(model_taken(flags, 4'b1010));
      flags = 5'b01000;
      accept(4'b1010, 16'h0202);
      expect_resp("lo_z", 1'b0, 16'h0202);
      finish_resp(1'b0);
      accept(4'b1111, 16'h0303);
      expect_resp("never", 1'b0, 16'h0303);
      finish_resp(1'b0);

      // Hazard: one older writer, NE against stale Z=1, Done 3 cycles later
      flags = 5'b01000;
      issue = 1; cycle(); issue = 0;
      accept(4'b0001, 16'h1234);
      check("haz_wait0", 32'(resp_valid), 32'd0);
      cycle(); check("haz_wait1", 32'(resp_valid), 32'd0);
      cycle(); check("haz_wait2", 32'(resp_valid), 32'd0);
      done = 1; cycle(); done = 0;
      flags = 5'b00000;
      check("haz_d_plus1", 32'(resp_valid), 32'd0);
      cycle();
      expect_resp("haz_d_plus2", 1'b1, 16'h1234);
      finish_resp(1'b1);

      // Issue in the accept cycle is younger: immediate evaluation; hold 5 cycles
      flags = 5'b00001;
      issue = 1;
      accept(4'b0010, 16'hBEEF);
      issue = 0;
      expect_resp("same_cyc", 1'b1, 16'hBEEF);
      for (int i = 0; i < 5; i++) begin
         flags = 5'b11110;
         cycle();
         expect_resp("hold", 1'b1, 16'hBEEF);
      end
      finish_resp(1'b1);
      done = 1; cycle(); done = 0;
      check("no_err_yet", 32'(err), 32'(m_err));

      // Done with nothing pending: sticky error
      done = 1; cycle(); done = 0;
      check("err_underflow", 32'(err), 32'd1);
      cycle(); cycle();
      check("err_sticky", 32'(err), 32'd1);

      // Fresh reset, then four Issues: saturate at 3 and flag the error
      rst_n = 0; #1;
      check("rst2_err", 32'(err), 32'd0);
      cycle(); rst_n = 1; cycle();
      for (int i = 0; i < 4; i++) begin issue = 1; cycle(); end
      issue = 0;
      check("err_overflow", 32'(err), 32'(m_err));
      accept(4'b1110, 16'h0777);
      check("sat_wait", 32'(resp_valid), 32'd0);
      done = 1;
      cycle(); check("sat_d1", 32'(resp_valid), 32'd0);
      cycle(); check("sat_d2", 32'(resp_valid), 32'd0);
      cycle(); done = 0;
      check("sat_d3_plus1", 32'(resp_valid), 32'd0);
      cycle();
      expect_resp("sat_resp", 1'b1, 16'h0777);
      finish_resp(1'b1);

      // Reset while waiting drops the request and clears the error
      done = 1; cycle(); done = 0;
      issue = 1; cycle(); issue = 0;
      accept(4'b0000, 16'h0999);
      check("mid_wait", 32'(resp_valid), 32'd0);
      rst_n = 0; #1;
      check("mid_rst_ready", 32'(req_ready),  32'd1);
      check("mid_rst_valid", 32'(resp_valid), 32'd0);
      check("mid_rst_err",   32'(err),        32'd0);
`ifdef BCU_STATS_EN
      check("mid_rst_taken_cnt", 32'(taken_cnt), 32'd0);
      check("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
      m_tc = 0;
`endif
      cycle(); rst_n = 1; cycle();
      check("post_rst_ready", 32'(req_ready), 32'd1);
      flags = 5'b01000;
      accept(4'b0000, 16'h0AAA);
      expect_resp("post_rst_fast", 1'b1, 16'h0AAA);
      finish_resp(1'b1);

      // Random requests with nothing pending
      for (int i = 0; i < 30; i++) begin
         fl = 5'($urandom); cc = 4'($urandom); tg = 16'($urandom);
         flags = fl;
         accept(cc, tg);
         flags = 5'($urandom);
         expect_resp("rnd_fast", model_taken(fl, cc), tg);
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            cycle();
            expect_resp("rnd_hold", model_taken(fl, cc), tg);
         end
         finish_resp(model_taken(fl, cc));
      end

      // Random hazards: k older writers retired with random spacing
      for (int i = 0; i < 10; i++) begin
         k = $urandom_range(1, MAXP);
         for (int j = 0; j < k; j++) begin issue = 1; cycle(); end
         issue = 0;
         cc = 4'($urandom); tg = 16'($urandom);
         flags = 5'($urandom);
         accept(cc, tg);
         check("rnd_haz_wait", 32'(resp_valid), 32'd0);
         for (int j = 0; j < k; j++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
               cycle();
               check("rnd_haz_gap", 32'(resp_valid), 32'd0);
            end
            done = 1; cycle(); done = 0;
            if (j < k - 1) check("rnd_haz_mid", 32'(resp_valid), 32'd0);
         end
         fl = 5'($urandom);
         flags = fl;
         check("rnd_haz_d1", 32'(resp_valid), 32'd0);
         cycle();
         expect_resp("rnd_haz_d2", model_taken(fl, cc), tg);
         finish_resp(model_taken(fl, cc));
      end

      check("final_err", 32'(err), 32'(m_err));
`ifdef BCU_STATS_EN
      check("final_taken_cnt", 32'(taken_cnt), 32'(m_tc));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Absolute time bound so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: observed no end expected end by 200000");
      $fatal(1, "timeout");
   end

endmodule
